// File: rtl/dmem_resp_if.sv
// dmem_resp_if: req/ack load-store handshake between the MEM stage and the data-memory responder
interface dmem_resp_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        ack;
    logic [31:0] rdata;
    logic        err;
    logic        busy;

    modport master (output req, we, addr, be, wdata, input ack, rdata, err, busy);
    modport slave  (input req, we, addr, be, wdata, output ack, rdata, err, busy);
endinterface

// File: rtl/dmem_resp.sv
// dmem_resp: multi-cycle word-organised data memory with wait states, byte-enabled stores and bad-address errors
module dmem_resp #(
    parameter int ADDR_W = 10,
    parameter int WAIT   = 2
) (
    input logic        clk,
    input logic        clr,
    dmem_resp_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [3:0]        be_q;
    logic [31:0]       wdata_q;
    logic [31:0]       mem [2**ADDR_W];
    logic [ADDR_W-1:0] idx;
    logic              bad;
    logic              accept;
    logic              respond;

    assign idx     = addr_q[ADDR_W+1:2];
    assign bad     = (addr_q[1:0] != 2'b00) || (|addr_q[31:ADDR_W+2]);
    assign accept  = (state == S_IDLE) && bus.req;
    assign respond = (state == S_RESP);

    // state register; reset abandons any transaction in flight
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= S_IDLE;
        else      state <= state_nx;
    end

    // next state: the wait phase is skipped entirely when WAIT is zero
    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (bus.req) state_nx = (WAIT > 0) ? S_WAIT : S_RESP;
            S_WAIT:  if (cnt == 4'd1) state_nx = S_RESP;
            default: state_nx = S_IDLE;
        endcase
    end

    // capture the request at acceptance and count down the wait states
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            cnt     <= 4'd0;
            we_q    <= 1'b0;
            addr_q  <= 32'd0;
            be_q    <= 4'd0;
            wdata_q <= 32'd0;
        end else if (accept) begin
            cnt     <= 4'(WAIT);
            we_q    <= bus.we;
            addr_q  <= bus.addr;
            be_q    <= bus.be;
            wdata_q <= bus.wdata;
        end else if (state == S_WAIT) begin
            cnt <= cnt - 4'd1;
        end
    end

    // registered response: ack/err pulse, busy window, load data held until the next ack
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            bus.ack   <= 1'b0;
            bus.err   <= 1'b0;
            bus.busy  <= 1'b0;
            bus.rdata <= 32'd0;
        end else begin
            bus.ack <= respond;
            bus.err <= respond && bad;
            if (accept)       bus.busy <= 1'b1;
            else if (respond) bus.busy <= 1'b0;
            if (respond && (bad || !we_q)) bus.rdata <= bad ? 32'd0 : mem[idx];
        end
    end

    // byte-lane store on the response edge; bad addresses never write
    always_ff @(posedge clk) begin
        if (respond && we_q && !bad)
            for (int i = 0; i < 4; i++)
                if (be_q[i]) mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp: directed checks of dmem_resp (WAIT=2 and WAIT=0) against a transaction-level model
module tb_dmem_resp;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int   hv  = 0;
    int   hm  = 0;

    always #5 clk = ~clk;

    dmem_resp_if bus [2] ();

    dmem_resp #(.ADDR_W(10), .WAIT(2)) dut0 (.clk(clk), .clr(clr), .bus(bus[0]));
    dmem_resp #(.ADDR_W(10), .WAIT(0)) dut1 (.clk(clk), .clr(clr), .bus(bus[1]));

    // per-instance model: a request taken at edge n completes at edge n+W+1
    for (genvar g = 0; g < 2; g++) begin : u
        localparam int W = (g == 0) ? 2 : 0;
        int          vec    = 0;
        int          miss   = 0;
        int          n      = 0;
        int          done   = 0;
        logic        pend   = 1'b0;
        logic        e_ack  = 1'b0;
        logic        e_err  = 1'b0;
        logic        e_busy = 1'b0;
        logic [31:0] e_rd   = 32'd0;
        logic [31:0] e_mk   = 32'hFFFF_FFFF;
        logic        t_we;
        logic [31:0] t_a;
        logic [31:0] t_wd;
        logic [3:0]  t_be;
        logic [31:0] mv [1024] = '{default: '0};
        logic [31:0] km [1024] = '{default: '0};

        // model update at every edge, reset asynchronously like the design
        always @(posedge clk or negedge clr) begin
            if (!clr) begin
                pend = 1'b0; e_ack = 1'b0; e_err = 1'b0; e_busy = 1'b0;
                e_rd = 32'd0; e_mk = 32'hFFFF_FFFF; n = 0;
            end else begin
                n++;
                e_ack = 1'b0;
                e_err = 1'b0;
                if (pend && n == done) begin
                    pend = 1'b0; e_busy = 1'b0; e_ack = 1'b1;
                    if (t_a[1:0] != 2'b00 || t_a >= 32'h1000) begin
                        e_err = 1'b1; e_rd = 32'd0; e_mk = 32'hFFFF_FFFF;
                    end else if (t_we) begin
                        for (int i = 0; i < 4; i++)
                            if (t_be[i]) begin
                                mv[t_a[11:2]][8*i +: 8] = t_wd[8*i +: 8];
                                km[t_a[11:2]][8*i +: 8] = 8'hFF;
                            end
                    end else begin
                        e_rd = mv[t_a[11:2]];
                        e_mk = km[t_a[11:2]];
                    end
                end else if (!pend && bus[g].req) begin
                    pend = 1'b1; e_busy = 1'b1; done = n + W + 1;
                    t_we = bus[g].we; t_a = bus[g].addr; t_be = bus[g].be; t_wd = bus[g].wdata;
                end
            end
        end

        // compare DUT outputs to the model every cycle, away from the clock edge
        always @(negedge clk) begin
            vec++;
            if (bus[g].ack !== e_ack || bus[g].err !== e_err || bus[g].busy !== e_busy ||
                ((bus[g].rdata ^ e_rd) & e_mk) != 32'd0) begin
                miss++;
                $display("FAIL u%0d model t=%0t ack/err/busy/rdata got %b/%b/%b/%h want %b/%b/%b/%h mask %h",
                         g, $time, bus[g].ack, bus[g].err, bus[g].busy, bus[g].rdata,
                         e_ack, e_err, e_busy, e_rd, e_mk);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        hv++;
        if (act !== want) begin
            hm++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // from the #1 point after the acceptance edge, count cycles until ack (bounded)
    task automatic wait_ack(output int lat);
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!bus[0].ack && lat < 40);
    endtask

    task automatic run0(input logic w, input logic [31:0] a, input logic [3:0] b, input logic [31:0] d,
                        output logic [31:0] rd, output logic er, output int lat);
        @(posedge clk); #1;
        bus[0].we = w; bus[0].addr = a; bus[0].be = b; bus[0].wdata = d; bus[0].req = 1'b1;
        @(posedge clk); #1;
        chk("busy_after_accept", 32'(bus[0].busy), 32'd1);
        bus[0].we = ~w; bus[0].addr = a ^ 32'h4; bus[0].be = ~b; bus[0].wdata = ~d;
        wait_ack(lat);
        chk("latency", 32'(lat), 32'd3);
        rd = bus[0].rdata;
        er = bus[0].err;
        bus[0].req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required finish before 200000");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        bus[1].req = 1'b0; bus[1].we = 1'b0; bus[1].addr = 32'd0; bus[1].be = 4'd0; bus[1].wdata = 32'd0;
        bus[0].req = 1'b1; bus[0].we = 1'b1; bus[0].addr = 32'h0; bus[0].be = 4'hF; bus[0].wdata = 32'h1234_5678;
        #2 clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ack", 32'(bus[0].ack), 32'd0);
        chk("reset_busy", 32'(bus[0].busy), 32'd0);
        chk("reset_err", 32'(bus[0].err), 32'd0);
        chk("reset_rdata", bus[0].rdata, 32'd0);
        clr = 1'b1;
        @(posedge clk); #1;
        chk("accept_first_edge", 32'(bus[0].busy), 32'd1);
        wait_ack(lat);
        chk("reset_store_latency", 32'(lat), 32'd3);
        bus[0].req = 1'b0;

        run0(1'b1, 32'h100, 4'hF, 32'hDEAD_BEEF, rd, er, lat);
        chk("store_err", 32'(er), 32'd0);
        chk("store_keeps_rdata", rd, 32'd0);
        run0(1'b0, 32'h100, 4'h0, 32'h0, rd, er, lat);
        chk("load_100", rd, 32'hDEAD_BEEF);
        chk("load_100_err", 32'(er), 32'd0);

        run0(1'b1, 32'h20, 4'hF, 32'h1122_3344, rd, er, lat);
        run0(1'b1, 32'h20, 4'h5, 32'hAABB_CCDD, rd, er, lat);
        run0(1'b0, 32'h20, 4'h0, 32'h0, rd, er, lat);
        chk("byte_enable_merge", rd, 32'h11BB_33DD);

        run0(1'b0, 32'h102, 4'hF, 32'h0, rd, er, lat);
        chk("misaligned_err", 32'(er), 32'd1);
        chk("misaligned_rdata", rd, 32'd0);

        run0(1'b0, 32'h100, 4'h0, 32'h0, rd, er, lat);
        run0(1'b1, 32'h1000, 4'hF, 32'hCAFE_F00D, rd, er, lat);
        chk("range_err", 32'(er), 32'd1);
        chk("range_rdata", rd, 32'd0);
        run0(1'b0, 32'h0, 4'h0, 32'h0, rd, er, lat);
        chk("word0_unchanged", rd, 32'h1234_5678);
        chk("word0_err", 32'(er), 32'd0);

        run0(1'b0, 32'h8000_0000, 4'h0, 32'h0, rd, er, lat);
        chk("high_bit_err", 32'(er), 32'd1);

        run0(1'b1, 32'h20, 4'h0, 32'hFFFF_FFFF, rd, er, lat);
        run0(1'b0, 32'h20, 4'h0, 32'h0, rd, er, lat);
        chk("be_zero_no_write", rd, 32'h11BB_33DD);

        run0(1'b1, 32'hFFC, 4'hF, 32'hA5A5_5A5A, rd, er, lat);
        run0(1'b0, 32'hFFC, 4'h0, 32'h0, rd, er, lat);
        chk("top_word", rd, 32'hA5A5_5A5A);
        chk("top_word_err", 32'(er), 32'd0);

        run0(1'b1, 32'h40, 4'hF, 32'h5555_AAAA, rd, er, lat);
        @(posedge clk); #1;
        bus[0].we = 1'b1; bus[0].addr = 32'h40; bus[0].be = 4'hF; bus[0].wdata = 32'hFFFF_FFFF; bus[0].req = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr = 1'b0;
        bus[0].req = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            chk("abandoned_no_ack", 32'(bus[0].ack), 32'd0);
        end
        clr = 1'b1;
        run0(1'b0, 32'h40, 4'h0, 32'h0, rd, er, lat);
        chk("abandoned_no_write", rd, 32'h5555_AAAA);

        @(posedge clk); #1;
        bus[1].req = 1'b1;
        for (int k = 0; k < 8; k++) begin
            bus[1].we    = (k < 4);
            bus[1].addr  = 32'((k % 4) * 4);
            bus[1].be    = 4'hF;
            bus[1].wdata = 32'h0A0B_0C00 + 32'(k);
            @(posedge clk); #1;
            chk("b2b_busy_high", 32'({bus[1].busy, bus[1].ack}), 32'b10);
            @(posedge clk); #1;
            chk("b2b_ack", 32'({bus[1].busy, bus[1].ack}), 32'b01);
            chk("b2b_rdata", bus[1].rdata, (k < 4) ? 32'd0 : 32'h0A0B_0C00 + 32'(k - 4));
        end
        bus[1].req = 1'b0;
        @(posedge clk); #1;
        chk("b2b_idle_after", 32'({bus[1].busy, bus[1].ack}), 32'b00);

        repeat (2) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", hv + u[0].vec + u[1].vec, hm + u[0].miss + u[1].miss);
        $finish;
    end
endmodule
